// File: rtl/sdf_fft_frame_ctrl.sv
// -----------------------------------------------------------------------------
// sdf_fft_frame_ctrl
//
// Frame sequencer in front of a radix-2 single-delay-feedback FFT pipeline.
// Upstream samples arrive on a valid/ready stream. Whole DATA_NUM-sample frames
// are issued to stage 1 with an enable that never drops inside a frame. Once a
// frame has started, a missing upstream sample is replaced by zero and flagged
// as an underrun. Gaps are legal only between frames.
// Samples leaving the last stage are indexed and counted. A run ends when the
// configured number of frames has been issued, or when a stop request arrives.
// The run is finished only after every issued frame has left the pipeline.
//
// Ports
//   clk, rstn      clock; asynchronous active-low reset
//   start          single-cycle run request; only honoured in IDLE
//   stop           single-cycle request to end the run after the current frame
//   cfg_frames     frames per run (0 = run until stop); latched on start
//   in_valid       upstream sample valid
//   in_data        upstream sample {re, im}
//   in_ready       sample accepted this cycle (decoded from state only)
//   pipe_en        data_i_en of stage 1 (registered, 1-cycle latency)
//   pipe_data      data_i of stage 1 (registered, 1-cycle latency)
//   pipe_o_en      data_o_en of the last stage
//   out_idx        position of the current output sample within its frame
//   out_last       pipe_o_en on the final sample of an output frame
//   frame_done     registered pulse one cycle after out_last
//   run_done       pulse when the run has fully drained
//   busy           controller outside IDLE
//   err_underrun   sticky underrun flag; cleared by an accepted start
// -----------------------------------------------------------------------------
module sdf_fft_frame_ctrl #(
  parameter  int DATA_NUM    = 1024,
  parameter  int DATA_WIDTH  = 64,
  parameter  int FRAME_CNT_W = 16,
  localparam int IDX_W       = $clog2(DATA_NUM)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic                   stop,
  input  logic [FRAME_CNT_W-1:0] cfg_frames,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   in_ready,
  output logic                   pipe_en,
  output logic [DATA_WIDTH-1:0]  pipe_data,
  input  logic                   pipe_o_en,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   out_last,
  output logic                   frame_done,
  output logic                   run_done,
  output logic                   busy,
  output logic                   err_underrun
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_SOF = 2'd1;
  localparam logic [1:0] RUN      = 2'd2;
  localparam logic [1:0] DRAIN    = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_NUM - 1);

  // Frame index advance; wraps at the last sample of a frame.
  function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
  endfunction

  // Frame counters wrap modulo 2^FRAME_CNT_W. Only equality is ever tested,
  // so the wrap is harmless in continuous mode.
  function automatic logic [FRAME_CNT_W-1:0] frm_next(input logic [FRAME_CNT_W-1:0] cnt);
    return cnt + FRAME_CNT_W'(1);
  endfunction

  logic [1:0]             state;
  logic [FRAME_CNT_W-1:0] cfg_lat;
  logic [FRAME_CNT_W-1:0] in_frames;
  logic [FRAME_CNT_W-1:0] out_frames;
  logic [IDX_W-1:0]       in_cnt;
  logic                   stop_pend;
  logic                   err_q;
  logic                   run_done_q;
  logic                   frame_done_q;
  logic [IDX_W-1:0]       out_idx_q;

  logic                   vld_p1;
  logic [DATA_WIDTH-1:0]  data_p1;

  logic                   accept;
  logic                   in_wrap;
  logic                   last_frame;
  logic                   start_ok;

  assign in_ready   = (state == WAIT_SOF) || (state == RUN);
  assign accept     = in_ready && in_valid;
  assign in_wrap    = (state == RUN) && (in_cnt == LAST_IDX);
  assign start_ok   = (state == IDLE) && start;
  // A stop arriving in the final cycle of a frame still ends the run at this
  // wrap. It does not wait for the pending flag to register.
  assign last_frame = stop || stop_pend ||
                      ((cfg_lat != '0) && (frm_next(in_frames) == cfg_lat));

  // ---- control: run state machine and input-side frame counting ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cfg_lat    <= '0;
      in_frames  <= '0;
      in_cnt     <= '0;
      stop_pend  <= 1'b0;
      err_q      <= 1'b0;
      run_done_q <= 1'b0;
      vld_p1     <= 1'b0;
    end else begin
      run_done_q <= 1'b0;
      vld_p1     <= 1'b0;

      if ((state != IDLE) && stop) begin
        stop_pend <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            cfg_lat   <= cfg_frames;
            in_frames <= '0;
            in_cnt    <= '0;
            err_q     <= 1'b0;
            stop_pend <= 1'b0;
            state     <= WAIT_SOF;
          end
        end

        WAIT_SOF: begin
          // A waiting sample takes priority over a stop in the same cycle.
          // That sample has already been handshaken, so it must not be dropped.
          // The stop is still recorded in stop_pend and ends the run after this frame.
          if (in_valid) begin
            vld_p1 <= 1'b1;
            in_cnt <= IDX_W'(1);
            state  <= RUN;
          end else if (stop || stop_pend) begin
            state <= DRAIN;
          end
        end

        RUN: begin
          // The SDF stages need a contiguous enable, so a frame never stalls.
          vld_p1 <= 1'b1;
          if (!in_valid) begin
            err_q <= 1'b1;
          end
          in_cnt <= idx_next(in_cnt);
          if (in_wrap) begin
            in_frames <= frm_next(in_frames);
            state     <= last_frame ? DRAIN : WAIT_SOF;
          end
        end

        DRAIN: begin
          if (out_frames == in_frames) begin
            run_done_q <= 1'b1;
            stop_pend  <= 1'b0;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage p1: sample register feeding stage 1 ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_p1 <= '0;
    end else if (accept) begin
      data_p1 <= in_data;
    end else if (state == RUN) begin
      data_p1 <= '0;
    end
  end

  // ---- output side: indexing of samples leaving the last stage ----
  assign out_last = pipe_o_en && (out_idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_idx_q    <= '0;
      out_frames   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= out_last;
      if (pipe_o_en) begin
        out_idx_q <= idx_next(out_idx_q);
      end
      if (start_ok) begin
        out_frames <= '0;
      end else if (out_last) begin
        out_frames <= frm_next(out_frames);
      end
    end
  end

  assign pipe_en      = vld_p1;
  assign pipe_data    = data_p1;
  assign out_idx      = out_idx_q;
  assign frame_done   = frame_done_q;
  assign run_done     = run_done_q;
  assign busy         = (state != IDLE);
  assign err_underrun = err_q;

endmodule

// File: tb/tb_sdf_fft_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sdf_fft_frame_ctrl
//
// Directed bench for sdf_fft_frame_ctrl with DATA_NUM=8. The FFT pipeline is
// stood in for by a fixed 4-cycle delay line from pipe_en to pipe_o_en. That
// delay line is cleared by rstn, just as the real stages would be reset.
// Inputs are driven on the falling edge. Outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_sdf_fft_frame_ctrl;

  localparam int DN = 8;
  localparam int DW = 16;
  localparam int FW = 16;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [FW-1:0] cfg_frames = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          pipe_en;
  logic [DW-1:0] pipe_data;
  logic          pipe_o_en;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          frame_done;
  logic          run_done;
  logic          busy;
  logic          err_underrun;

  always #5 clk = ~clk;

  sdf_fft_frame_ctrl #(
    .DATA_NUM   (DN),
    .DATA_WIDTH (DW),
    .FRAME_CNT_W(FW)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .stop        (stop),
    .cfg_frames  (cfg_frames),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .pipe_en     (pipe_en),
    .pipe_data   (pipe_data),
    .pipe_o_en   (pipe_o_en),
    .out_idx     (out_idx),
    .out_last    (out_last),
    .frame_done  (frame_done),
    .run_done    (run_done),
    .busy        (busy),
    .err_underrun(err_underrun)
  );

  // Pipeline stand-in: pipe_o_en follows pipe_en four cycles later.
  logic [3:0] dly;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) dly <= '0;
    else       dly <= {dly[2:0], pipe_en};
  end
  assign pipe_o_en = dly[3];

  int checks = 0;
  int errors = 0;

  // Reference model state and per-run observations.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] pd_hist [0:63];
  int  fpos = 0, oidx = 0, cyc = 0;
  int  slot_cnt, pe_cnt, pe_rises, pe_first, start_cyc;
  int  ol_cnt, ol_last_cyc, fd_cnt, fd_last_cyc, rd_cnt, rd_cyc;
  int  data_bad, idx_bad;
  logic prev_pe = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // One clock cycle: drive inputs, then sample and score the outputs.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic st, input logic sp);
    logic [DW-1:0] e;
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    start    = st;
    stop     = sp;
    #1;
    // Inside a frame, every in_ready cycle consumes one slot. Zero fills a missing sample.
    if (in_ready && (in_valid || fpos != 0)) begin
      exp_q.push_back(in_valid ? in_data : '0);
      fpos = (fpos + 1) % DN;
      slot_cnt++;
    end
    if (pipe_en === 1'b1) begin
      if (prev_pe !== 1'b1) pe_rises++;
      if (pe_cnt == 0) pe_first = cyc;
      if (pe_cnt < 64) pd_hist[pe_cnt] = pipe_data;
      pe_cnt++;
      if (exp_q.size() == 0) data_bad++;
      else begin
        e = exp_q.pop_front();
        if (pipe_data !== e) data_bad++;
      end
    end
    prev_pe = pipe_en;
    if (pipe_o_en === 1'b1) begin
      if (out_idx !== IW'(oidx)) idx_bad++;
      if (out_last !== (oidx == DN - 1)) idx_bad++;
      if (oidx == DN - 1) begin
        ol_cnt++;
        ol_last_cyc = cyc;
      end
      oidx = (oidx + 1) % DN;
    end else if (out_last !== 1'b0) begin
      idx_bad++;
    end
    if (frame_done === 1'b1) begin
      fd_cnt++;
      fd_last_cyc = cyc;
    end
    if (run_done === 1'b1) begin
      rd_cnt++;
      rd_cyc = cyc;
    end
    cyc++;
  endtask

  // Start a run, then stream samples until run_done or the cycle budget.
  // A slot argument of -1 disables that event.
  task automatic run(input int cfg, input int pre_gap, input int under_slot,
                     input int stop_slot, input int bstart_slot, input logic stop_with_start,
                     input int rst_slot, input int budget);
    int g, n;
    logic v, st, sp;
    bit u_done, s_done, b_done;
    slot_cnt = 0; pe_cnt = 0; pe_rises = 0; pe_first = -100;
    ol_cnt = 0; ol_last_cyc = -100; fd_cnt = 0; fd_last_cyc = -100;
    rd_cnt = 0; rd_cyc = -100; data_bad = 0; idx_bad = 0;
    u_done = 0; s_done = 0; b_done = 0;
    cfg_frames = FW'(cfg);
    start_cyc = cyc;
    step(1'b0, '0, 1'b1, stop_with_start);
    g = pre_gap;
    n = 0;
    while (rd_cnt == 0 && n < budget) begin
      if (rst_slot >= 0 && slot_cnt == rst_slot) break;
      v = 1'b1; st = 1'b0; sp = 1'b0;
      if (g > 0) begin
        v = 1'b0;
        g--;
      end
      if (!u_done && slot_cnt == under_slot) begin
        v = 1'b0;
        u_done = 1;
      end
      if (!s_done && slot_cnt == stop_slot) begin
        sp = 1'b1;
        s_done = 1;
      end
      if (!b_done && slot_cnt == bstart_slot) begin
        st = 1'b1;
        b_done = 1;
        cfg_frames = FW'(5);
      end
      step(v, 16'h8000 | 16'(cyc), st, sp);
      n++;
    end
    if (rst_slot < 0) begin
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
    end
  endtask

  task automatic check_run(input string n, input int pe, input int fr, input logic er);
    check({n, "_pe_cnt"}, pe_cnt, pe);
    check({n, "_pe_contig"}, pe_rises, 1);
    check({n, "_accepted"}, slot_cnt, pe);
    check({n, "_data"}, data_bad, 0);
    check({n, "_out_idx"}, idx_bad, 0);
    check({n, "_out_last"}, ol_cnt, fr);
    check({n, "_frame_done"}, fd_cnt, fr);
    check({n, "_fd_after_last"}, fd_last_cyc - ol_last_cyc, 1);
    check({n, "_run_done"}, rd_cnt, 1);
    check({n, "_rd_after_fd"}, rd_cyc - fd_last_cyc, 1);
    check({n, "_err"}, err_underrun, er);
    check({n, "_busy_end"}, busy, 0);
    check({n, "_ready_end"}, in_ready, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_pipe_en", pipe_en, 0);
    check("rst_pipe_data", pipe_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_run_done", run_done, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_underrun, 0);
    @(negedge clk);
    rstn = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    check("idle_busy", busy, 0);
    check("idle_ready", in_ready, 0);

    // Two back-to-back frames
    run(2, 0, -1, -1, -1, 1'b0, -1, 200);
    check_run("s1", 16, 2, 1'b0);
    check("s1_latency", pe_first - start_cyc, 2);

    // Three idle cycles before the first sample
    run(1, 3, -1, -1, -1, 1'b0, -1, 200);
    check_run("s2", 8, 1, 1'b0);
    check("s2_latency", pe_first - start_cyc, 5);

    // Underrun at sample 4
    run(1, 0, 4, -1, -1, 1'b0, -1, 200);
    check_run("s3", 8, 1, 1'b1);
    check("s3_zero_fill", pd_hist[4], 0);
    check("s3_sample3", pd_hist[3] != 0, 1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0);
    check("s3_err_sticky", err_underrun, 1);

    // Continuous mode, stop during sample 3 of frame 5
    run(0, 0, -1, 35, -1, 1'b0, -1, 400);
    check_run("s4", 40, 5, 1'b0);
    check("s4_rd_after_last", rd_cyc - ol_last_cyc, 2);

    // start+stop together in IDLE, then a start while busy
    run(2, 0, 3, -1, 12, 1'b1, -1, 300);
    check_run("s5", 16, 2, 1'b1);

    // Reset during sample 5 of frame 1
    run(2, 0, 2, -1, -1, 1'b0, 5, 300);
    check("s6_err_before", err_underrun, 1);
    check("s6_busy_before", busy, 1);
    #2;
    rstn = 1'b0;
    #1;
    check("s6_rst_in_ready", in_ready, 0);
    check("s6_rst_pipe_en", pipe_en, 0);
    check("s6_rst_busy", busy, 0);
    check("s6_rst_err", err_underrun, 0);
    in_valid = 1'b0;
    exp_q.delete();
    fpos = 0;
    oidx = 0;
    prev_pe = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    check("s6_idle_after", busy, 0);
    run(2, 0, -1, -1, -1, 1'b0, -1, 200);
    check_run("s6", 16, 2, 1'b0);
    check("s6_latency", pe_first - start_cyc, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
